// File: rtl/my_arbiter_pkg.sv
// my_arbiter_pkg: shared widths and types for the 4-way round-robin arbiter and its mux
package my_arbiter_pkg;
   localparam int WIDTH = 16;
   localparam int NUM_CH = 4;
   typedef logic [1:0] ch_idx_t;
   typedef logic [WIDTH-1:0] word_t;
endpackage

// File: rtl/my_mux_4_way.sv
// my_mux_4_way: 4-to-1 word multiplexer selected by a channel index
module my_mux_4_way
   import my_arbiter_pkg::*;
(
   input  word_t   a,
   input  word_t   b,
   input  word_t   c,
   input  word_t   d,
   input  ch_idx_t sel,
   output word_t   out
);
   always_comb out = sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);
endmodule

// File: rtl/my_arbiter_4_way.sv
// my_arbiter_4_way: one-word-per-channel buffered round-robin arbiter with a registered
// valid/ready output stage
module my_arbiter_4_way
   import my_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  word_t             a,
   input  word_t             b,
   input  word_t             c,
   input  word_t             d,
   input  logic [NUM_CH-1:0] in_valid,
   output logic [NUM_CH-1:0] in_ready,
   output word_t             out,
   output ch_idx_t           out_src,
   output logic              out_valid,
   input  logic              out_ready
);
   // rotate so ptr sits at bit 0, take the lowest set bit, then rotate the index back
   function automatic logic [2:0] rr_pick(input logic [NUM_CH-1:0] full, input ch_idx_t start);
      logic [2*NUM_CH-1:0] dbl;
      ch_idx_t off;
      dbl = {full, full} >> start;
      off = 2'd0;
      for (int k = NUM_CH - 1; k >= 0; k--) if (dbl[k]) off = ch_idx_t'(k);
      return {|full, ch_idx_t'(start + off)};
   endfunction

   logic [NUM_CH-1:0] hold_full;
   word_t             hold_data [NUM_CH];
   word_t             in_data [NUM_CH];
   ch_idx_t           ptr;
   ch_idx_t           grant;
   logic              any_full;
   logic              free;
   logic              take;
   word_t             mux_out;

   always_comb begin
      in_data[0] = a;
      in_data[1] = b;
      in_data[2] = c;
      in_data[3] = d;
      {any_full, grant} = rr_pick(hold_full, ptr);
      free = !out_valid || out_ready;
      take = free && any_full;
      in_ready = ~hold_full;
   end

   my_mux_4_way u_mux (
      .a   (hold_data[0]),
      .b   (hold_data[1]),
      .c   (hold_data[2]),
      .d   (hold_data[3]),
      .sel (grant),
      .out (mux_out)
   );

   // accept only into an empty slot, so a slot drained this edge refills no earlier than the next
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_full <= '0;
         for (int i = 0; i < NUM_CH; i++) hold_data[i] <= '0;
         ptr <= '0;
         out <= '0;
         out_src <= '0;
         out_valid <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (in_valid[i] && !hold_full[i]) begin
               hold_data[i] <= in_data[i];
               hold_full[i] <= 1'b1;
            end else if (take && grant == ch_idx_t'(i)) begin
               hold_full[i] <= 1'b0;
            end
         end
         if (free) begin
            out_valid <= any_full;
            if (any_full) begin
               out <= mux_out;
               out_src <= grant;
               ptr <= grant + 2'd1;
            end
         end
      end
   end
endmodule
